crc_frame_sequencer: RTL

Per-frame controller for the pixel CRC pipeline (packer -> 4-pixel collector -> 192b CRC32). It gates pixel valids into the pipeline and clears the CRC at frame start. At frame end it pads any partial 4-pixel group with zero pixels, waits out the pipeline latency, and captures the frame CRC. The result is presented with a pixel count and frame ID through a valid/ready handshake for register readout or link-level comparison.

---
 rtl/crc_frame_sequencer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/crc_frame_sequencer.sv
// crc_frame_sequencer
// Per-frame controller for the pixel CRC pipeline. Gates pixel valids into
// the packer/collector/CRC chain, clears the CRC at frame start, pads the
// last partial 4-pixel group with zero pixels, waits out the pipeline
// latency and captures the frame CRC with its pixel count and frame ID.
//
// Result handshake: result_valid rises on capture and stays high, with all
// result_* fields stable, until a cycle in which result_ready=1; it drops on
// the following edge. A capture landing while a result is still pending
// and not being accepted overwrites it and sets the sticky overrun flag; a
// capture in the same cycle as an accept simply loads the new result.
module crc_frame_sequencer #(
    parameter int CNT_W       = 24,
    parameter int CRC_LATENCY = 2,
    parameter int FID_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             frame_start,
    input  logic             frame_end,
    input  logic             pix_in_valid,
    input  logic [31:0]      crc_in,
    output logic             pipe_pixel_valid,
    output logic             pipe_pad,
    output logic             pipe_clear,
    output logic [31:0]      result_crc,
    output logic [CNT_W-1:0] result_pix_count,
    output logic [FID_W-1:0] result_frame_id,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             busy,
    output logic             overrun,
    output logic             frame_abort,
    output logic             stray_pixel,
    input  logic             flag_clr,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_ACTIVE = 3'd2,
        S_PAD    = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    // DRAIN runs CRC_LATENCY+1 cycles so the capture sits one cycle past
    // the point where crc_in first reflects the final group.
    localparam logic [3:0] DRAIN_LAST = 4'(CRC_LATENCY);

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       lane;
    logic [1:0]       lane_adv;
    logic [CNT_W-1:0] pix_cnt;
    logic [FID_W-1:0] frame_id;
    logic [3:0]       drain_cnt;
    logic             capture;
    logic             abort_req;

    assign lane_adv  = lane + {1'b0, pix_in_valid};
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and pipeline control outputs.
    always_comb begin
        state_nxt        = state;
        pipe_pixel_valid = 1'b0;
        pipe_pad         = 1'b0;
        pipe_clear       = 1'b0;
        capture          = 1'b0;
        abort_req        = 1'b0;
        case (state)
            S_IDLE: begin
                if (frame_start && enable) state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                pipe_clear = 1'b1;
                state_nxt  = S_ACTIVE;
            end
            S_ACTIVE: begin
                pipe_pixel_valid = pix_in_valid;
                if (frame_start) begin
                    abort_req = 1'b1;
                    state_nxt = S_CLEAR;
                end else if (frame_end) begin
                    // Same-cycle pixel already included in lane_adv.
                    state_nxt = (lane_adv != 2'd0) ? S_PAD : S_DRAIN;
                end
            end
            S_PAD: begin
                pipe_pixel_valid = 1'b1;
                pipe_pad         = 1'b1;
                if (frame_start) begin
                    abort_req = 1'b1;
                    state_nxt = S_CLEAR;
                end else if (lane == 2'd3) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (frame_start) begin
                    abort_req = 1'b1;
                    state_nxt = S_CLEAR;
                end else if (drain_cnt == DRAIN_LAST) begin
                    capture   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Lane position, pixel count, drain timer and frame ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane      <= 2'd0;
            pix_cnt   <= '0;
            drain_cnt <= 4'd0;
            frame_id  <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    lane    <= 2'd0;
                    pix_cnt <= '0;
                end
                S_ACTIVE: begin
                    if (pix_in_valid) begin
                        lane <= lane + 2'd1;
                        if (pix_cnt != {CNT_W{1'b1}}) pix_cnt <= pix_cnt + CNT_W'(1);
                    end
                end
                S_PAD: lane <= lane + 2'd1;
                default: ;
            endcase
            if (state == S_DRAIN) drain_cnt <= drain_cnt + 4'd1;
            else                  drain_cnt <= 4'd0;
            if (capture) frame_id <= frame_id + FID_W'(1);
        end
    end

    // Result registers and valid/ready handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_crc       <= 32'd0;
            result_pix_count <= '0;
            result_frame_id  <= '0;
            result_valid     <= 1'b0;
        end else if (capture) begin
            result_crc       <= crc_in;
            result_pix_count <= pix_cnt;
            result_frame_id  <= frame_id;
            result_valid     <= 1'b1;
        end else if (result_valid && result_ready) begin
            result_valid <= 1'b0;
        end
    end

    // Sticky error flags; a clear outranks a same-cycle set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun     <= 1'b0;
            frame_abort <= 1'b0;
            stray_pixel <= 1'b0;
        end else if (flag_clr) begin
            overrun     <= 1'b0;
            frame_abort <= 1'b0;
            stray_pixel <= 1'b0;
        end else begin
            if (capture && result_valid && !result_ready) overrun <= 1'b1;
            if (abort_req) frame_abort <= 1'b1;
            if (pix_in_valid && (state != S_ACTIVE)) stray_pixel <= 1'b1;
        end
    end

endmodule
